// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code receiver: FSM encoding,
// prefix bytes and the decoded-key entry layout.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam int         KEY_W   = 10;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ps2_key_t;

endpackage

// File: rtl/ps2_key_fifo.sv
// Show-ahead FIFO for decoded keys with a registered head entry and a
// one-cycle overflow pulse when a push is dropped.
module ps2_key_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         ready,
    output logic [W-1:0] head,
    output logic         valid,
    output logic         overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, wr_next, rd_next;
    logic          full, do_pop, do_push;

    // Handshake: the head entry is consumed on any cycle where valid && ready;
    // valid never drops while the FIFO holds an entry, and head is stable until popped.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = valid && ready;
    assign do_push = push && (!full || do_pop);
    assign wr_next = wr_ptr + PW'(do_push);
    assign rd_next = rd_ptr + PW'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            valid    <= 1'b0;
            head     <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= wr_next;
            rd_ptr   <= rd_next;
            valid    <= (wr_next != rd_next);
            overflow <= push && full && !do_pop;
            // The entry being written this cycle may become the new head.
            if (do_push && (rd_next == wr_ptr)) begin
                head <= push_data;
            end else begin
                head <= mem[rd_next[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronise and filter the bus, deframe 11-bit
// frames, fold E0/F0 prefixes into flags and queue decoded keys.
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 4,
    parameter bit PARITY_CHECK   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kb_clk,
    input  logic       kb_data,
    output logic [7:0] code,
    output logic       is_break,
    output logic       is_ext,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow
);
    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   clk_s, data_s;
    logic                   clk_filt, filt_hit, fall;
    logic [FCW-1:0]         filt_cnt;

    ps2_state_t     state;
    logic [2:0]     bit_cnt;
    logic [7:0]     shreg, byte_q;
    logic           par_bit, byte_stb, frame_bad;
    logic [TOW-1:0] to_cnt;
    logic           ext_pend, brk_pend, key_push;
    ps2_key_t       head_key;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], kb_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], kb_data};
        end
    end

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

    // filt_cnt counts consecutive samples that disagree with clk_filt.
    assign filt_hit = (clk_s != clk_filt) && (filt_cnt == FCW'(FILTER_LEN - 1));
    assign fall     = filt_hit && clk_filt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s == clk_filt) begin
            filt_cnt <= '0;
        end else if (filt_hit) begin
            clk_filt <= clk_s;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FCW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            to_cnt     <= '0;
            byte_q     <= '0;
            byte_stb   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            frame_bad  <= 1'b0;
        end else begin
            byte_stb   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            frame_bad  <= 1'b0;
            to_cnt     <= (state == ST_IDLE || fall) ? '0 : to_cnt + TOW'(1);
            // A stalled partial frame is dropped; prefix flags survive it.
            if (state != ST_IDLE && !fall && to_cnt == TO_LAST) begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
            end else if (fall) begin
                case (state)
                    ST_IDLE: begin
                        if (data_s) begin
                            frame_err <= 1'b1;
                            frame_bad <= 1'b1;
                        end else begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {data_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_bit <= data_s;
                        state   <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (!data_s) begin
                            frame_err <= 1'b1;
                            frame_bad <= 1'b1;
                        end else if (PARITY_CHECK && !(^{shreg, par_bit})) begin
                            parity_err <= 1'b1;
                            frame_bad  <= 1'b1;
                        end else begin
                            byte_stb <= 1'b1;
                            byte_q   <= shreg;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign key_push = byte_stb && (byte_q != PS2_EXT) && (byte_q != PS2_BRK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (byte_stb) begin
            if (byte_q == PS2_EXT) begin
                ext_pend <= 1'b1;
            end else if (byte_q == PS2_BRK) begin
                brk_pend <= 1'b1;
            end else begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end
        end else if (frame_bad) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end
    end

    ps2_key_fifo #(
        .DEPTH(FIFO_DEPTH),
        .W    (KEY_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (key_push),
        .push_data({byte_q, brk_pend, ext_pend}),
        .ready    (code_ready),
        .head     (head_key),
        .valid    (code_valid),
        .overflow (overflow)
    );

    assign code     = head_key.code;
    assign is_break = head_key.brk;
    assign is_ext   = head_key.ext;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx: two instances (parity enforced / ignored)
// share one PS/2 bus; a monitor pops expected keys as the FIFOs present them.
module tb_ps2_scan_rx;
  localparam int SYNC  = 2;
  localparam int FILT  = 4;
  localparam int TMO   = 50;
  localparam int DEPTH = 4;
  localparam int HALF  = 10;
  localparam int LAT   = SYNC + FILT + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic kb_clk = 1'b1;
  logic kb_data = 1'b1;
  logic code_ready = 1'b1;

  logic [7:0] code_a, code_b;
  logic is_break_a, is_ext_a, code_valid_a, parity_err_a, frame_err_a, overflow_a;
  logic is_break_b, is_ext_b, code_valid_b, parity_err_b, frame_err_b, overflow_b;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int stop_cyc = 0;
  int rise_a = -1;
  logic cv_prev_a = 1'b0;
  int par_a = 0, frm_a = 0, ovf_a = 0;
  int par_b = 0, frm_b = 0, ovf_b = 0;
  logic [9:0] exp_a[$];
  logic [9:0] exp_b[$];

  ps2_scan_rx #(
    .SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO),
    .FIFO_DEPTH(DEPTH), .PARITY_CHECK(1'b1)
  ) u_dut (
    .clk(clk), .rst(rst), .kb_clk(kb_clk), .kb_data(kb_data),
    .code(code_a), .is_break(is_break_a), .is_ext(is_ext_a),
    .code_valid(code_valid_a), .code_ready(code_ready),
    .parity_err(parity_err_a), .frame_err(frame_err_a), .overflow(overflow_a)
  );

  ps2_scan_rx #(
    .SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO),
    .FIFO_DEPTH(DEPTH), .PARITY_CHECK(1'b0)
  ) u_dut_np (
    .clk(clk), .rst(rst), .kb_clk(kb_clk), .kb_data(kb_data),
    .code(code_b), .is_break(is_break_b), .is_ext(is_ext_b),
    .code_valid(code_valid_b), .code_ready(code_ready),
    .parity_err(parity_err_b), .frame_err(frame_err_b), .overflow(overflow_b)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check_eq(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_key(input logic [7:0] c, input logic brk, input logic ext,
                            input bit to_a, input bit to_b);
    if (to_a) exp_a.push_back({c, brk, ext});
    if (to_b) exp_b.push_back({c, brk, ext});
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (code_valid_a && !cv_prev_a) rise_a = cyc;
      if (code_valid_a && code_ready) begin
        if (exp_a.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL key_a: unexpected entry 0x%0h, expected none", {code_a, is_break_a, is_ext_a});
        end else begin
          check_eq("key_a", int'({code_a, is_break_a, is_ext_a}), int'(exp_a.pop_front()));
        end
      end
      if (code_valid_b && code_ready) begin
        if (exp_b.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL key_b: unexpected entry 0x%0h, expected none", {code_b, is_break_b, is_ext_b});
        end else begin
          check_eq("key_b", int'({code_b, is_break_b, is_ext_b}), int'(exp_b.pop_front()));
        end
      end
      if (parity_err_a) par_a++;
      if (frame_err_a)  frm_a++;
      if (overflow_a)   ovf_a++;
      if (parity_err_b) par_b++;
      if (frame_err_b)  frm_b++;
      if (overflow_b)   ovf_b++;
    end
    cv_prev_a = code_valid_a;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    kb_data = b;
    tick(HALF);
    kb_clk = 1'b0;
    tick(HALF);
    kb_clk = 1'b1;
  endtask

  task automatic glitch();
    tick(8);
    kb_clk = 1'b0;
    tick(2);
    kb_clk = 1'b1;
    tick(8);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input int glitch_after);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i]);
      if (i == glitch_after) glitch();
    end
    send_bit((~^d) ^ bad_par);
    kb_data = 1'b1;
    tick(HALF);
    kb_clk = 1'b0;
    stop_cyc = cyc;
    tick(HALF);
    kb_clk = 1'b1;
    tick(HALF);
  endtask

  task automatic send_partial(input int nbits);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(i[0]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    tick(5);
    check_eq("rst_code", int'(code_a), 0);
    check_eq("rst_flags", int'({is_break_a, is_ext_a}), 0);
    check_eq("rst_valid", int'(code_valid_a), 0);
    check_eq("rst_errs", int'({parity_err_a, frame_err_a, overflow_a}), 0);
    check_eq("rst_valid_np", int'(code_valid_b), 0);
    rst = 1'b0;
    tick(20);

    // Plain make code and its latency from the stop-bit Fall
    expect_key(8'h1C, 1'b0, 1'b0, 1'b1, 1'b1);
    rise_a = -1;
    send_frame(8'h1C, 1'b0, -1);
    tick(10);
    check_eq("latency", rise_a - stop_cyc, LAT);
    check_eq("err_clean", par_a + frm_a + ovf_a, 0);

    // Extended release, then a plain make
    expect_key(8'h75, 1'b1, 1'b1, 1'b1, 1'b1);
    expect_key(8'h1C, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'hE0, 1'b0, -1);
    send_frame(8'hF0, 1'b0, -1);
    send_frame(8'h75, 1'b0, -1);
    send_frame(8'h1C, 1'b0, -1);
    tick(10);
    check_eq("drain_prefix", exp_a.size() + exp_b.size(), 0);

    // Bad parity: rejected when enforced, accepted when ignored
    expect_key(8'h1C, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b1, -1);
    tick(10);
    check_eq("par_a", par_a, 1);
    check_eq("par_b", par_b, 0);
    check_eq("valid_after_par", int'(code_valid_a), 0);
    check_eq("drain_par", exp_a.size() + exp_b.size(), 0);

    // Timeout on a partial frame, then a clean frame
    send_partial(4);
    tick(TMO + 30);
    check_eq("tmo_frm_a", frm_a, 1);
    check_eq("tmo_frm_b", frm_b, 1);
    expect_key(8'h29, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'h29, 1'b0, -1);
    tick(10);
    check_eq("drain_tmo", exp_a.size() + exp_b.size(), 0);

    // Short clock glitches: idle (a Fall here would be a frame error) and mid-frame
    kb_clk = 1'b0;
    tick(2);
    kb_clk = 1'b1;
    tick(20);
    check_eq("glitch_idle_frm", frm_a, 1);
    expect_key(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'h5A, 1'b0, 3);
    tick(10);
    check_eq("glitch_frm", frm_a + par_a, 2);
    check_eq("drain_glitch", exp_a.size() + exp_b.size(), 0);

    // Fill the FIFO; the fifth key is dropped
    code_ready = 1'b0;
    expect_key(8'h15, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_key(8'h1D, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_key(8'h24, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_key(8'h2D, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'h15, 1'b0, -1);
    send_frame(8'h1D, 1'b0, -1);
    send_frame(8'h24, 1'b0, -1);
    send_frame(8'h2D, 1'b0, -1);
    check_eq("ovf_before", ovf_a, 0);
    send_frame(8'h2C, 1'b0, -1);
    tick(10);
    check_eq("ovf_a", ovf_a, 1);
    check_eq("ovf_b", ovf_b, 1);
    check_eq("full_valid", int'(code_valid_a), 1);
    check_eq("full_head", int'(code_a), 8'h15);
    code_ready = 1'b1;
    tick(10);
    check_eq("drained_valid", int'(code_valid_a), 0);
    check_eq("drain_ovf", exp_a.size() + exp_b.size(), 0);

    // Asynchronous reset in the middle of a frame with a key held
    code_ready = 1'b0;
    send_frame(8'h1C, 1'b0, -1);
    tick(5);
    check_eq("held_valid", int'(code_valid_a), 1);
    send_partial(3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("async_valid", int'(code_valid_a), 0);
    check_eq("async_code", int'(code_a), 0);
    tick(3);
    rst = 1'b0;
    code_ready = 1'b1;
    tick(HALF * 4);
    check_eq("post_rst_valid", int'(code_valid_a), 0);
    expect_key(8'h29, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'h29, 1'b0, -1);
    tick(10);
    check_eq("final_frm_a", frm_a, 1);
    check_eq("final_par_a", par_a, 1);
    check_eq("final_q_a", exp_a.size(), 0);
    check_eq("final_q_b", exp_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_scan_rx.md
Name: ps2_scan_rx

Overview:
Parametrised PS/2 keyboard receiver that replaces the fixed-function front end of keyboard_top. It synchronises and glitch-filters kb_clk/kb_data and deframes 11-bit PS/2 frames with start/parity/stop checking and an inactivity timeout. It folds E0/F0 prefixes into per-key flags and buffers decoded keys in a FIFO with a valid/ready interface toward the display/number logic.

Parameters:
SYNC_STAGES, 2, synchroniser flops on kb_clk and kb_data (min 2)
FILTER_LEN, 4, consecutive equal kb_clk samples needed to change the filtered clock (min 1)
TIMEOUT_CYCLES, 100000, clk cycles without a filtered falling edge before a partial frame is aborted
FIFO_DEPTH, 4, decoded-key FIFO entries (power of 2, min 2)
PARITY_CHECK, 1, 1 = enforce odd parity; 0 = ignore the parity bit

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
kb_clk  in  1  raw PS/2 clock from the keyboard
kb_data  in  1  raw PS/2 data from the keyboard
code  out  8  scan code at the FIFO head
is_break  out  1  head key is a release (F0 seen)
is_ext  out  1  head key is extended (E0 seen)
code_valid  out  1  FIFO non-empty
code_ready  in  1  consumer accepts the head entry when code_valid && code_ready
parity_err  out  1  one-cycle pulse on a parity failure
frame_err  out  1  one-cycle pulse on a bad start bit, bad stop bit or timeout
overflow  out  1  one-cycle pulse when a decoded key is dropped because the FIFO is full

Behaviour:
- Reset is asynchronous, active-high and fixed as such. All state clears. Outputs: code=0, is_break=0, is_ext=0, code_valid=0, all error pulses 0. Synchroniser and filter registers reset to 1 (idle bus). The FSM goes to IDLE, the prefix flags clear and the FIFO empties.
- Synchroniser: SYNC_STAGES flops per input.
- Filter: the filtered clock changes only after FILTER_LEN consecutive synchronised samples differ from its current value. Shorter pulses are ignored.
- Fall: a one-cycle strobe on a filtered 1->0 transition. kb_data (synchronised) is sampled only in a Fall cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: a Fall with data=0 goes to DATA with the bit counter at 0. A Fall with data=1 pulses frame_err and stays in IDLE.
  - DATA: each Fall shifts data in LSB-first. After the 8th bit, go to PARITY.
  - PARITY: a Fall latches the parity bit and goes to STOP.
  - STOP: a Fall goes to IDLE. Stop=0 pulses frame_err and discards the byte. Otherwise, if PARITY_CHECK=1 and the 9 bits (data plus parity) have even weight, pulse parity_err and discard the byte. Otherwise issue a byte strobe.
- Timeout: a counter resets on every Fall and while in IDLE. In any non-IDLE state, reaching TIMEOUT_CYCLES aborts to IDLE and pulses frame_err. Bits of the partial frame are discarded; the prefix flags are kept.
- Decoder (acts in the cycle after the byte strobe):
  - 0xE0 sets ext_pend.
  - 0xF0 sets brk_pend.
  - Any other byte pushes {code, brk_pend, ext_pend} into the FIFO and clears both flags.
  - A discarded or erroneous frame clears both pending flags.
- Latency: if the stop-bit Fall occurs in cycle T with the FIFO empty, code_valid rises in cycle T+2.
- FIFO: show-ahead; code/is_break/is_ext are registered outputs of the head entry.
  - Pop when code_valid && code_ready.
  - Push and pop in the same cycle are both performed, even when full. Occupancy is unchanged and no overflow occurs.
  - Push when full without a pop drops the new entry and pulses overflow; stored entries are untouched.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- Error pulses are mutually exclusive per frame and last exactly one cycle.
- Reset mid-frame abandons the frame immediately. A frame already in flight on the bus after reset release is not deframed until the next start bit seen in IDLE. A 1 seen in IDLE raises frame_err, which is the required behaviour.

Decomposition:
- Shared package ps2_pkg holds:
  - the FSM state encoding constants;
  - the prefix constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0;
  - the FIFO entry width constant (10).
- One sub-module: ps2_key_fifo (parametrised by FIFO_DEPTH and width, with the full/empty/overflow logic). The synchroniser, filter, FSM and decoder stay in ps2_scan_rx.

Test Plan:
- Frame 0x1C (start 0; data 0,0,1,1,1,0,0,0; parity 0; stop 1) -> one FIFO entry code=0x1C, is_break=0, is_ext=0; code_valid rises exactly 2 cycles after the stop Fall; no error pulses.
- Frames E0, F0, 75 -> a single entry code=0x75, is_break=1, is_ext=1; the following frame 1C -> entry 0x1C with both flags 0.
- Frame 0x1C with parity bit 1 -> parity_err pulses for 1 cycle, FIFO stays empty. With PARITY_CHECK=0, the same frame yields entry 0x1C.
- Start bit plus 4 data bits, then idle for TIMEOUT_CYCLES (bench sets 50) -> frame_err pulses once, FSM back in IDLE; a subsequent clean 0x29 frame is received correctly.
- FIFO_DEPTH=4, code_ready=0, send keys 0x15, 0x1D, 0x24, 0x2D, 0x2C -> the 5th pulses overflow. Then with code_ready=1, pops 0x15, 0x1D, 0x24, 0x2D in order and code_valid drops.
- 2-cycle low glitch on kb_clk with FILTER_LEN=4 -> no Fall and no state change. rst asserted mid-DATA -> outputs zero immediately (asynchronously), no entry from the aborted frame.
